// File: rtl/cc_miss_handler.sv
// cc_miss_handler: single-outstanding cache line fill engine (AR request, 8-beat fill, tag update).
module cc_miss_handler (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_i,
    input  logic [16:0] tag_i,
    input  logic [8:0]  index_i,
    input  logic [5:0]  offset_i,
    output logic        mem_arvalid_o,
    output logic [31:0] mem_araddr_o,
    input  logic        mem_arready_i,
    input  logic        mem_rvalid_i,
    input  logic [63:0] mem_rdata_i,
    input  logic        mem_rlast_i,
    output logic        mem_rready_o,
    output logic        data_wren_o,
    output logic [11:0] data_waddr_o,
    output logic [63:0] data_wdata_o,
    output logic        tag_wren_o,
    output logic [8:0]  tag_waddr_o,
    output logic [17:0] tag_wdata_o,
    output logic        rvalid_o,
    output logic [63:0] rdata_o,
    output logic        busy_o,
    output logic        fill_done_o,
    output logic        err_o
);
    typedef enum logic [1:0] {IDLE, REQ, FILL, UPDATE} state_t;

    state_t      r_state, w_next;
    logic [16:0] r_tag;
    logic [8:0]  r_index;
    logic [2:0]  r_crit;
    logic [2:0]  r_beat;
    logic        r_err;
    logic        w_beat;
    logic        w_unused;

    assign w_unused = ^offset_i[2:0];
    assign w_beat   = (r_state == FILL) && mem_rvalid_i;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = miss_i ? REQ : IDLE;
            REQ:     w_next = mem_arready_i ? FILL : REQ;
            FILL:    w_next = (w_beat && r_beat == 3'd7) ? UPDATE : FILL;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_tag   <= '0;
            r_index <= '0;
            r_crit  <= '0;
            r_beat  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && miss_i) begin
                r_tag   <= tag_i;
                r_index <= index_i;
                r_crit  <= offset_i[5:3];
            end
            // counter wraps 7->0, so each fill starts at beat 0
            if (w_beat) r_beat <= r_beat + 3'd1;
            if (w_beat && (mem_rlast_i != (r_beat == 3'd7))) r_err <= 1'b1;
        end
    end

    // data outputs are forced to 0 with their strobes so reset leaves every output low
    assign mem_arvalid_o = (r_state == REQ);
    assign mem_araddr_o  = mem_arvalid_o ? {r_tag, r_index, 6'b0} : '0;
    assign mem_rready_o  = (r_state == FILL);
    assign data_wren_o   = w_beat;
    assign data_waddr_o  = w_beat ? {r_index, r_beat} : '0;
    assign data_wdata_o  = w_beat ? mem_rdata_i : '0;
    assign rvalid_o      = w_beat && (r_beat == r_crit);
    assign rdata_o       = rvalid_o ? mem_rdata_i : '0;
    assign tag_wren_o    = (r_state == UPDATE);
    assign tag_waddr_o   = tag_wren_o ? r_index : '0;
    assign tag_wdata_o   = tag_wren_o ? {1'b1, r_tag} : '0;
    assign fill_done_o   = tag_wren_o;
    assign busy_o        = (r_state != IDLE);
    assign err_o         = r_err;
endmodule

// File: tb/tb_cc_miss_handler.sv
// tb_cc_miss_handler: randomized fills checked against a transaction-level model of the miss handler.
module tb_cc_miss_handler;
  logic        clk = 1'b0;
  logic        rst, miss_i, mem_arready_i, mem_rvalid_i, mem_rlast_i;
  logic [16:0] tag_i;
  logic [8:0]  index_i;
  logic [5:0]  offset_i;
  logic [63:0] mem_rdata_i;
  logic        mem_arvalid_o, mem_rready_o, data_wren_o, tag_wren_o, rvalid_o, busy_o, fill_done_o, err_o;
  logic [31:0] mem_araddr_o;
  logic [11:0] data_waddr_o;
  logic [63:0] data_wdata_o, rdata_o;
  logic [8:0]  tag_waddr_o;
  logic [17:0] tag_wdata_o;
  int          total = 0;
  int          bad = 0;
  logic        m_err;
  cc_miss_handler dut (
    .clk(clk), .rst(rst), .miss_i(miss_i), .tag_i(tag_i), .index_i(index_i), .offset_i(offset_i),
    .mem_arvalid_o(mem_arvalid_o), .mem_araddr_o(mem_araddr_o), .mem_arready_i(mem_arready_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_rlast_i(mem_rlast_i),
    .mem_rready_o(mem_rready_o), .data_wren_o(data_wren_o), .data_waddr_o(data_waddr_o),
    .data_wdata_o(data_wdata_o), .tag_wren_o(tag_wren_o), .tag_waddr_o(tag_waddr_o),
    .tag_wdata_o(tag_wdata_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .busy_o(busy_o),
    .fill_done_o(fill_done_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  task automatic chk(input string n, input bit ok);
    total++;
    if (!ok) begin
      bad++;
      $error("FAIL %s", n);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_idle(input string n);
    chk({n, "_busy"}, busy_o === 1'b0);
    chk({n, "_strobes"}, |{mem_arvalid_o, mem_rready_o, data_wren_o, tag_wren_o, rvalid_o, fill_done_o} === 1'b0);
    chk({n, "_err"}, err_o === m_err);
  endtask
  task automatic chk_reset(input string n);
    chk(n, |{mem_arvalid_o, mem_araddr_o, mem_rready_o, data_wren_o, data_waddr_o, data_wdata_o,
             tag_wren_o, tag_waddr_o, tag_wdata_o, rvalid_o, rdata_o, busy_o, fill_done_o, err_o} === 1'b0);
  endtask
  task automatic do_reset();
    rst = 1'b1; miss_i = 1'b0; mem_arready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0;
    mem_rdata_i = {$urandom, $urandom};
    step();
    m_err = 1'b0;
    chk_reset("reset_outputs");
    rst = 1'b0;
  endtask
  task automatic fill(input logic [16:0] t, input logic [8:0] ix, input logic [5:0] off, input int ardly,
                      input int gmin, input int gmax, input int early, input int rbeat, input bit spam);
    logic [63:0] d;
    int g;
    int nw = 0;
    miss_i = 1'b1; tag_i = t; index_i = ix; offset_i = off;
    #1;
    chk_idle("idle_pre");
    step();
    miss_i = 1'b0;
    for (int c = 0; c <= ardly; c++) begin
      mem_arready_i = (c == ardly);
      if (spam) begin miss_i = 1'($urandom); tag_i = 17'($urandom); index_i = 9'($urandom); end
      #1;
      chk("req_arvalid", mem_arvalid_o === 1'b1);
      chk("req_araddr", mem_araddr_o === {t, ix, 6'b0});
      chk("req_busy", busy_o === 1'b1);
      chk("req_quiet", |{mem_rready_o, data_wren_o, tag_wren_o, rvalid_o, fill_done_o} === 1'b0);
      step();
    end
    mem_arready_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == rbeat) begin
        do_reset();
        chk("reset_no_tag_write", tag_wren_o === 1'b0);
        return;
      end
      g = int'($urandom_range(gmax, gmin));
      for (int c = 0; c <= g; c++) begin
        mem_rvalid_i = (c == g);
        d = {$urandom, $urandom};
        mem_rdata_i = d;
        mem_rlast_i = (c == g) ? ((k == 7) ^ (k == early)) : 1'($urandom);
        if (spam) begin miss_i = 1'($urandom); tag_i = 17'($urandom); index_i = 9'($urandom); end
        #1;
        chk("fill_rready", mem_rready_o === 1'b1);
        chk("fill_no_ar", mem_arvalid_o === 1'b0);
        chk("fill_no_tag", (tag_wren_o | fill_done_o) === 1'b0);
        chk("fill_busy", busy_o === 1'b1);
        chk("fill_err", err_o === m_err);
        chk("fill_wren", data_wren_o === (c == g));
        chk("fill_rvalid", rvalid_o === ((c == g) && (3'(k) == off[5:3])));
        if (c == g) begin
          nw++;
          chk("fill_waddr", data_waddr_o === {ix, 3'(k)});
          chk("fill_wdata", data_wdata_o === d);
          if (3'(k) == off[5:3]) chk("fill_rdata", rdata_o === d);
        end
        step();
        if (c == g && k == early) m_err = 1'b1;
      end
    end
    chk("fill_write_count", nw == 8);
    mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0;
    miss_i = 1'b1; tag_i = 17'($urandom); index_i = 9'($urandom);
    #1;
    chk("upd_tag_wren", tag_wren_o === 1'b1);
    chk("upd_tag_waddr", tag_waddr_o === ix);
    chk("upd_tag_wdata", tag_wdata_o === {1'b1, t});
    chk("upd_fill_done", fill_done_o === 1'b1);
    chk("upd_busy", busy_o === 1'b1);
    chk("upd_quiet", |{data_wren_o, mem_rready_o, mem_arvalid_o, rvalid_o} === 1'b0);
    chk("upd_err", err_o === m_err);
    step();
    miss_i = 1'b0;
    #1;
    chk_idle("idle_post");
    step();
    chk_idle("idle_miss_ignored");
  endtask
  initial begin
    tag_i = '0; index_i = '0; offset_i = '0;
    do_reset();
    step();
    rst = 1'b1;
    step();
    chk_reset("reset_hold");
    rst = 1'b0;
    fill(17'h1ABCD, 9'h055, 6'h00, 0, 0, 0, -1, -1, 1'b0);
    fill(17'h1ABCD, 9'h055, 6'h00, 0, 0, 0, -1, -1, 1'b0);
    miss_i = 1'b1; tag_i = 17'h1ABCD; index_i = 9'h055; offset_i = 6'h00;
    step();
    miss_i = 1'b0;
    #1;
    chk("basic_araddr_const", mem_araddr_o === 32'hD5E6_9540);
    do_reset();
    fill(17'h0F00F, 9'h1A3, 6'h15, 5, 1, 3, -1, -1, 1'b0);
    fill(17'h12345, 9'h0FF, 6'h38, 0, 0, 1, -1, -1, 1'b0);
    fill(17'h00001, 9'h001, 6'h08, 1, 0, 2, 3, -1, 1'b0);
    chk("err_sticky", err_o === 1'b1);
    fill(17'h1FFFF, 9'h1FF, 6'h3F, 2, 0, 2, -1, -1, 1'b1);
    fill(17'h0AAAA, 9'h0AA, 6'h20, 1, 0, 1, -1, 4, 1'b0);
    chk("err_after_reset", err_o === 1'b0);
    fill(17'h15555, 9'h155, 6'h10, 0, 0, 1, -1, -1, 1'b0);
    for (int i = 0; i < 14; i++) begin
      int e;
      e = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
      fill(17'($urandom), 9'($urandom), 6'($urandom), int'($urandom_range(4, 0)), 0,
           int'($urandom_range(3, 0)), e, ($urandom_range(5, 0) == 0) ? int'($urandom_range(7, 0)) : -1,
           1'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cc_miss_handler.md
CC_MISS_HANDLER -- requirements
Module: CC_MISS_HANDLER

Interface
REQ-001 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 miss_i  in  1  one-cycle miss pulse from tag comparison stage.
REQ-005 tag_i / index_i / offset_i  in  17/9/6  tag, index and offset of the missing access, valid with miss_i.
REQ-006 mem_arvalid_o  out  1, mem_araddr_o  out  32, mem_arready_i  in  1  line-fill read request channel.
REQ-007 mem_rvalid_i  in  1, mem_rdata_i  in  64, mem_rlast_i  in  1, mem_rready_o  out  1  read data channel.
REQ-008 data_wren_o  out  1, data_waddr_o  out  12, data_wdata_o  out  64  data array write port.
REQ-009 tag_wren_o  out  1, tag_waddr_o  out  9, tag_wdata_o  out  18  tag array write port ({valid, tag}).
REQ-010 rvalid_o  out  1, rdata_o  out  64  critical word returned to requester.
REQ-011 busy_o  out  1  high while a fill is in progress; upstream stalls on it.
REQ-012 fill_done_o  out  1  one-cycle pulse on fill completion.
REQ-013 err_o  out  1  sticky burst-length error flag.

Function
REQ-014 FSM states SHALL be IDLE, REQ, FILL, UPDATE; encoding is free.
REQ-015 IDLE: miss_i=1 -> latch tag_i, index_i and offset_i; go to REQ on the next cycle.
REQ-016 REQ: mem_arvalid_o=1; mem_araddr_o={latched tag, latched index, 6'b0}; address SHALL hold stable until mem_arready_i=1, then go to FILL.
REQ-017 FILL: mem_rready_o=1; each cycle with mem_rvalid_i=1 is one beat; beat counter is 3 bits, starting at 0.
REQ-018 Per beat: data_wren_o=1, data_waddr_o={latched index, beat}, data_wdata_o=mem_rdata_i, all in the same cycle, combinational from the inputs.
REQ-019 When beat == latched offset[5:3]: rvalid_o=1 and rdata_o=mem_rdata_i in that same cycle; this SHALL occur exactly once per fill.
REQ-020 The beat with counter 7 SHALL end FILL and go to UPDATE, regardless of mem_rlast_i.
REQ-021 mem_rlast_i=1 on a beat other than 7, or mem_rlast_i=0 on beat 7, SHALL set err_o; err_o clears only on reset.
REQ-022 After an early rlast the FSM SHALL stay in FILL and keep accepting beats until counter 7.
REQ-023 UPDATE (one cycle): tag_wren_o=1, tag_waddr_o=latched index, tag_wdata_o={1'b1, latched tag}, fill_done_o=1; then go to IDLE.
REQ-024 busy_o SHALL be 1 in REQ, FILL and UPDATE, and 0 in IDLE.
REQ-025 miss_i SHALL be ignored outside IDLE; only one outstanding fill is allowed.
REQ-026 miss_i in the same cycle that UPDATE returns to IDLE is ignored; a miss is accepted only while the state is IDLE.
REQ-027 The tag array write SHALL follow the last data write, so a line is never marked valid before its data is complete.
REQ-028 In IDLE, all strobes (arvalid, rready, wren, rvalid_o, fill_done_o) SHALL be 0.
REQ-029 Data and address outputs are don't-care while their strobes are 0.

Reset
REQ-030 rst=1 SHALL force state IDLE, beat counter 0, latched fields 0 and err_o 0.
REQ-031 During rst=1 every output SHALL be 0 in the following cycle.
REQ-032 Reset mid-REQ or mid-FILL SHALL abandon the fill without any tag write; the memory side is reset concurrently.

Verification
REQ-033 Basic fill: miss_i with tag=0x1ABCD, index=0x055, offset=0x00; arready=1 in the first REQ cycle -> araddr=0xD5E6_9540; 8 data writes at addresses 0x2A8-0x2AF; rvalid_o on beat 0; tag write {1,0x1ABCD} at 0x055; fill_done_o 1 cycle; busy_o low afterwards.
REQ-034 Backpressure: arready held low for 5 cycles, rvalid gaps of 1-3 cycles -> araddr stable throughout; exactly 8 data writes; no writes in gap cycles.
REQ-035 Critical word: offset=0x38 -> rvalid_o only on beat 7, carrying the beat-7 data.
REQ-036 Burst error: rlast on beat 3 -> err_o=1 from the next cycle; fill still completes with 8 writes and a tag write.
REQ-037 Second miss_i during FILL -> ignored; no second AR request.
REQ-038 Reset at beat 4 -> all outputs 0, no tag_wren_o; a new miss after reset starts a fresh fill from beat 0.
